// File: rtl/doc_edit_pkg.sv
// Shared types and constants for the keystroke-to-document write sequencer.
package doc_edit_pkg;

  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 5;
  localparam int unsigned ADDR_W = ROW_W + COL_W;

  localparam logic [7:0] KEY_BS    = 8'h08;
  localparam logic [7:0] KEY_LF    = 8'h0A;
  localparam logic [7:0] KEY_CR    = 8'h0D;
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLR_WAIT
  } state_t;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADV,
    CUR_RET,
    CUR_NL,
    CUR_HOME
  } cur_cmd_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/doc_cursor.sv
// Row/column cursor with advance, retreat, newline and home commands.
module doc_cursor
  import doc_edit_pkg::*;
#(
  parameter int unsigned ROWS = 15,
  parameter int unsigned COLS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  cur_cmd_t         cmd,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] prev_row_c,
  output logic [COL_W-1:0] prev_col_c,
  output logic             at_origin,
  output logic             at_end
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  assign at_origin = (row == '0) && (col == '0);
  assign at_end    = (row == LAST_ROW) && (col == LAST_COL);

  // Cell one position behind the cursor; only meaningful when not at origin.
  always_comb begin
    prev_row_c = row;
    prev_col_c = col - COL_W'(1);
    if (col == '0) begin
      prev_row_c = row - ROW_W'(1);
      prev_col_c = LAST_COL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else begin
      case (cmd)
        CUR_ADV: begin
          if (!at_end) begin
            if (col == LAST_COL) begin
              row <= row + ROW_W'(1);
              col <= '0;
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        CUR_RET: begin
          if (!at_origin) begin
            row <= prev_row_c;
            col <= prev_col_c;
          end
        end
        CUR_NL: begin
          if (row != LAST_ROW) begin
            row <= row + ROW_W'(1);
            col <= '0;
          end
        end
        CUR_HOME: begin
          row <= '0;
          col <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/doc_edit_ctrl.sv
// Keystroke-to-document write sequencer: decodes keys, tracks the cursor and
// drives display write/clear strobes, holding keys off while the RAM is wiped.
module doc_edit_ctrl
  import doc_edit_pkg::*;
#(
  parameter int unsigned ROWS         = 15,
  parameter int unsigned COLS         = 20,
  parameter int unsigned CLEAR_CYCLES = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [7:0]        key_data,
  output logic              key_ready,
  input  logic              clear_req,
  output logic [ADDR_W-1:0] write_addr,
  output logic [7:0]        write_in_data,
  output logic              write_ready,
  output logic              clear_data,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col,
  output logic              busy,
  output logic              doc_full
);

  localparam int unsigned CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  state_t            state;
  logic [CNT_W-1:0]  clr_cnt;
  logic              clr_pend;

  cur_cmd_t          cur_cmd_c;
  logic [ROW_W-1:0]  prev_row_c;
  logic [COL_W-1:0]  prev_col_c;
  logic              at_origin;
  logic              at_end;

  logic              clr_go_c;
  logic              key_acc_c;
  logic              do_wr_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [7:0]        wr_data_c;
  logic              set_full_c;
  logic              clr_full_c;

  doc_cursor #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_cursor (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cur_cmd_c),
    .row        (cursor_row),
    .col        (cursor_col),
    .prev_row_c (prev_row_c),
    .prev_col_c (prev_col_c),
    .at_origin  (at_origin),
    .at_end     (at_end)
  );

  // Key decode; a pending clear also holds keys off so none is lost to it.
  always_comb begin
    key_ready  = (state == IDLE) && !clear_req && !clr_pend;
    clr_go_c   = (state == IDLE) && (clear_req || clr_pend);
    key_acc_c  = key_valid && key_ready;
    cur_cmd_c  = CUR_NONE;
    do_wr_c    = 1'b0;
    wr_addr_c  = {cursor_row, cursor_col};
    wr_data_c  = key_data;
    set_full_c = 1'b0;
    clr_full_c = 1'b0;
    if (clr_go_c) begin
      cur_cmd_c = CUR_HOME;
    end else if (key_acc_c) begin
      if (is_printable(key_data)) begin
        if (!doc_full) begin
          do_wr_c    = 1'b1;
          cur_cmd_c  = CUR_ADV;
          set_full_c = at_end;
        end
      end else if ((key_data == KEY_CR) || (key_data == KEY_LF)) begin
        cur_cmd_c = CUR_NL;
      end else if (key_data == KEY_BS) begin
        wr_data_c = CHR_SPACE;
        if (doc_full) begin
          do_wr_c    = 1'b1;
          clr_full_c = 1'b1;
        end else if (!at_origin) begin
          do_wr_c   = 1'b1;
          cur_cmd_c = CUR_RET;
          wr_addr_c = {prev_row_c, prev_col_c};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= CLR_WAIT;
      clr_cnt       <= CNT_W'(CLEAR_CYCLES - 1);
      clr_pend      <= 1'b0;
      busy          <= 1'b1;
      doc_full      <= 1'b0;
      write_ready   <= 1'b0;
      clear_data    <= 1'b0;
      write_addr    <= '0;
      write_in_data <= '0;
    end else begin
      write_ready <= 1'b0;
      clear_data  <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_go_c) begin
            state      <= CLR_WAIT;
            clr_cnt    <= CNT_W'(CLEAR_CYCLES - 1);
            clr_pend   <= 1'b0;
            busy       <= 1'b1;
            clear_data <= 1'b1;
            doc_full   <= 1'b0;
          end else if (key_acc_c) begin
            state       <= WRITE;
            write_ready <= do_wr_c;
            if (do_wr_c) begin
              write_addr    <= wr_addr_c;
              write_in_data <= wr_data_c;
            end
            if (set_full_c) begin
              doc_full <= 1'b1;
            end else if (clr_full_c) begin
              doc_full <= 1'b0;
            end
          end
        end
        WRITE: begin
          state <= IDLE;
          if (clear_req) begin
            clr_pend <= 1'b1;
          end
        end
        CLR_WAIT: begin
          if (clr_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_doc_edit_ctrl.sv
// Directed bench for doc_edit_ctrl with hand-computed expectations.
module tb_doc_edit_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_data;
  logic       key_ready;
  logic       clear_req;
  logic [9:0] write_addr;
  logic [7:0] write_in_data;
  logic       write_ready;
  logic       clear_data;
  logic [4:0] cursor_row;
  logic [4:0] cursor_col;
  logic       busy;
  logic       doc_full;

  int checks = 0;
  int errors = 0;

  doc_edit_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_data      (key_data),
    .key_ready     (key_ready),
    .clear_req     (clear_req),
    .write_addr    (write_addr),
    .write_in_data (write_in_data),
    .write_ready   (write_ready),
    .clear_data    (clear_data),
    .cursor_row    (cursor_row),
    .cursor_col    (cursor_col),
    .busy          (busy),
    .doc_full      (doc_full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (key_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (key_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_ready_timeout: key_ready=%b required 1", key_ready);
    end
  endtask

  task automatic send_key(input logic [7:0] k, output logic wr,
                          output logic [9:0] a, output logic [7:0] d);
    wait_ready();
    key_valid = 1'b1;
    key_data  = k;
    step();
    key_valid = 1'b0;
    wr = write_ready;
    a  = write_addr;
    d  = write_in_data;
    step();
  endtask

  task automatic do_clear();
    wait_ready();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    wait_ready();
  endtask

  task automatic test_reset();
    int n = 0;
    logic wr;
    rst = 1'b1; key_valid = 1'b0; key_data = 8'h00; clear_req = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0 || write_ready !== 1'b0 || clear_data !== 1'b0 ||
        doc_full !== 1'b0 || write_addr !== 10'h000 || write_in_data !== 8'h00 ||
        cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b kr=%b wr=%b cd=%b full=%b addr=%h data=%h cur=(%0d,%0d) required busy=1 rest 0",
               busy, key_ready, write_ready, clear_data, doc_full, write_addr, write_in_data,
               cursor_row, cursor_col);
    end
    step();
    rst = 1'b0;
    key_valid = 1'b1;
    key_data  = 8'h41;
    while (key_ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL post_reset_block: key_ready low for %0d cycles required 512", n);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_busy: busy=%b required 0", busy);
    end
    step();
    key_valid = 1'b0;
    wr = write_ready;
    checks++;
    if (wr !== 1'b1 || write_addr !== 10'h000 || write_in_data !== 8'h41 || cursor_col !== 5'd1) begin
      errors++;
      $display("FAIL first_key: wr=%b addr=%h data=%h col=%0d required 1 000 41 1",
               wr, write_addr, write_in_data, cursor_col);
    end
    step();
  endtask

  task automatic test_line_wrap();
    logic wr; logic [9:0] a; logic [7:0] d;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      send_key(8'h61 + 8'(i), wr, a, d);
      if (i == 0) begin
        checks++;
        if (wr !== 1'b1 || a !== 10'h000 || d !== 8'h61) begin
          errors++;
          $display("FAIL line_first: wr=%b addr=%h data=%h required 1 000 61", wr, a, d);
        end
      end
    end
    checks++;
    if (wr !== 1'b1 || a !== 10'h013 || d !== 8'h74 || cursor_row !== 5'd1 || cursor_col !== 5'd0) begin
      errors++;
      $display("FAIL line_wrap: wr=%b addr=%h data=%h cur=(%0d,%0d) required 1 013 74 (1,0)",
               wr, a, d, cursor_row, cursor_col);
    end
  endtask

  task automatic test_fill();
    logic wr; logic [9:0] a; logic [7:0] d;
    int writes = 0;
    do_clear();
    for (int i = 0; i < 299; i++) begin
      send_key(8'h30 + 8'(i % 10), wr, a, d);
      if (wr === 1'b1) writes++;
    end
    checks++;
    if (doc_full !== 1'b0 || cursor_row !== 5'd14 || cursor_col !== 5'd19) begin
      errors++;
      $display("FAIL fill_299: full=%b cur=(%0d,%0d) required 0 (14,19)", doc_full, cursor_row, cursor_col);
    end
    send_key(8'h5A, wr, a, d);
    if (wr === 1'b1) writes++;
    checks++;
    if (writes != 300 || a !== 10'h1D3 || d !== 8'h5A || doc_full !== 1'b1 ||
        cursor_row !== 5'd14 || cursor_col !== 5'd19) begin
      errors++;
      $display("FAIL fill_last: writes=%0d addr=%h data=%h full=%b cur=(%0d,%0d) required 300 1d3 5a 1 (14,19)",
               writes, a, d, doc_full, cursor_row, cursor_col);
    end
    send_key(8'h42, wr, a, d);
    checks++;
    if (wr !== 1'b0 || doc_full !== 1'b1) begin
      errors++;
      $display("FAIL full_drop: wr=%b full=%b required 0 1", wr, doc_full);
    end
    send_key(8'h08, wr, a, d);
    checks++;
    if (wr !== 1'b1 || a !== 10'h1D3 || d !== 8'h20 || doc_full !== 1'b0 ||
        cursor_row !== 5'd14 || cursor_col !== 5'd19) begin
      errors++;
      $display("FAIL full_bs: wr=%b addr=%h data=%h full=%b cur=(%0d,%0d) required 1 1d3 20 0 (14,19)",
               wr, a, d, doc_full, cursor_row, cursor_col);
    end
  endtask

  task automatic test_backspace();
    logic wr; logic [9:0] a; logic [7:0] d;
    do_clear();
    for (int i = 0; i < 20; i++) send_key(8'h78, wr, a, d);
    send_key(8'h0D, wr, a, d);
    send_key(8'h08, wr, a, d);
    checks++;
    if (wr !== 1'b1 || a !== 10'h033 || d !== 8'h20 || cursor_row !== 5'd1 || cursor_col !== 5'd19) begin
      errors++;
      $display("FAIL bs_row_wrap: wr=%b addr=%h data=%h cur=(%0d,%0d) required 1 033 20 (1,19)",
               wr, a, d, cursor_row, cursor_col);
    end
    send_key(8'h08, wr, a, d);
    checks++;
    if (wr !== 1'b1 || a !== 10'h032 || cursor_row !== 5'd1 || cursor_col !== 5'd18) begin
      errors++;
      $display("FAIL bs_mid: wr=%b addr=%h cur=(%0d,%0d) required 1 032 (1,18)", wr, a, cursor_row, cursor_col);
    end
    do_clear();
    send_key(8'h08, wr, a, d);
    checks++;
    if (wr !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      errors++;
      $display("FAIL bs_origin: wr=%b cur=(%0d,%0d) required 0 (0,0)", wr, cursor_row, cursor_col);
    end
  endtask

  task automatic test_newline();
    logic wr; logic [9:0] a; logic [7:0] d;
    do_clear();
    for (int i = 0; i < 14; i++) send_key(8'h0A, wr, a, d);
    for (int i = 0; i < 5; i++) send_key(8'h2E, wr, a, d);
    send_key(8'h0D, wr, a, d);
    checks++;
    if (wr !== 1'b0 || cursor_row !== 5'd14 || cursor_col !== 5'd5) begin
      errors++;
      $display("FAIL cr_last_row: wr=%b cur=(%0d,%0d) required 0 (14,5)", wr, cursor_row, cursor_col);
    end
    do_clear();
    for (int i = 0; i < 3; i++) send_key(8'h0D, wr, a, d);
    for (int i = 0; i < 7; i++) send_key(8'h2E, wr, a, d);
    send_key(8'h0D, wr, a, d);
    checks++;
    if (wr !== 1'b0 || cursor_row !== 5'd4 || cursor_col !== 5'd0) begin
      errors++;
      $display("FAIL cr_mid: wr=%b cur=(%0d,%0d) required 0 (4,0)", wr, cursor_row, cursor_col);
    end
    send_key(8'h2E, wr, a, d);
    send_key(8'h01, wr, a, d);
    checks++;
    if (wr !== 1'b0 || cursor_row !== 5'd4 || cursor_col !== 5'd1) begin
      errors++;
      $display("FAIL other_code: wr=%b cur=(%0d,%0d) required 0 (4,1)", wr, cursor_row, cursor_col);
    end
  endtask

  task automatic test_clear();
    logic wr; logic [9:0] a; logic [7:0] d;
    int n;
    send_key(8'h2E, wr, a, d);
    wait_ready();
    clear_req = 1'b1; key_valid = 1'b1; key_data = 8'h5A;
    #1;
    checks++;
    if (key_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_blocks_key: key_ready=%b required 0", key_ready);
    end
    step();
    clear_req = 1'b0; key_valid = 1'b0;
    checks++;
    if (clear_data !== 1'b1 || write_ready !== 1'b0 || busy !== 1'b1 ||
        cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      errors++;
      $display("FAIL clear_start: cd=%b wr=%b busy=%b cur=(%0d,%0d) required 1 0 1 (0,0)",
               clear_data, write_ready, busy, cursor_row, cursor_col);
    end
    n = 1;
    step();
    checks++;
    if (clear_data !== 1'b0) begin
      errors++;
      $display("FAIL clear_pulse_width: cd=%b required 0", clear_data);
    end
    while (busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL clear_busy_len: busy for %0d cycles required 512", n);
    end
    // clear request raised during the WRITE cycle
    send_key(8'h2E, wr, a, d);
    wait_ready();
    key_valid = 1'b1; key_data = 8'h6D;
    step();
    key_valid = 1'b0; clear_req = 1'b1;
    checks++;
    if (write_ready !== 1'b1 || write_addr !== 10'h001) begin
      errors++;
      $display("FAIL write_before_clear: wr=%b addr=%h required 1 001", write_ready, write_addr);
    end
    step();
    clear_req = 1'b0;
    checks++;
    if (clear_data !== 1'b0) begin
      errors++;
      $display("FAIL pending_clear_early: cd=%b required 0", clear_data);
    end
    step();
    checks++;
    if (clear_data !== 1'b1 || busy !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      errors++;
      $display("FAIL pending_clear: cd=%b busy=%b cur=(%0d,%0d) required 1 1 (0,0)",
               clear_data, busy, cursor_row, cursor_col);
    end
    wait_ready();
  endtask

  task automatic test_async_reset();
    key_valid = 1'b1; key_data = 8'h51;
    step();
    key_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (write_ready !== 1'b0 || busy !== 1'b1 || key_ready !== 1'b0 || cursor_col !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: wr=%b busy=%b kr=%b col=%0d required 0 1 0 0",
               write_ready, busy, key_ready, cursor_col);
    end
    step();
    rst = 1'b0;
    wait_ready();
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_fill();
    test_backspace();
    test_newline();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
